ram_unit: RTL and testbench

//  Word-addressed synchronous RAM slave sitting directly downstream of the motherboard
//  RAM sequencer. Serves single-word read/write requests signalled on ram_ctrl pins.

---
 rtl/ram_unit.sv | 118 +++++++++++
 tb/tb_ram_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_unit.sv
// Word-addressed synchronous RAM slave with a four-phase req/ACK handshake,
// programmable access latency and error flagging of illegal requests.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif
`ifndef RAM_ERR
`define RAM_ERR 1
`endif

module ram_unit #(
  parameter int word_width = `WORD_WIDTH,
  parameter int addr_bits  = 10,
  parameter int latency    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [word_width-1:0] ram_ctrl,
  output logic [word_width-1:0] ram_stat,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, WAIT, ACKED} state_t;

  state_t                 state;
  logic [7:0]             cnt;
  logic                   op_write;
  logic                   op_err;
  logic [addr_bits-1:0]   addr_q;
  logic [word_width-1:0]  data_q;
  logic                   ack_q;
  logic                   err_q;
  logic [word_width-1:0]  mem [0:(1<<addr_bits)-1];

  logic rd_pin;
  logic wr_pin;
  logic req_err;
  logic mem_we;
  logic unused_ctrl;

  assign rd_pin  = ram_ctrl[`RAM_READ_PIN];
  assign wr_pin  = ram_ctrl[`RAM_WRITE_PIN];
  // Conflicting pins or any address bit above the implemented range is illegal.
  assign req_err = (rd_pin && wr_pin) || ((addr >> addr_bits) != '0);
  assign mem_we  = (state == WAIT) && (cnt == 8'd0) && op_write && !op_err;
  // Remaining ctrl bits carry no meaning for this block.
  assign unused_ctrl = ^ram_ctrl;

  // NOTE: storage has no reset; clearing a RAM array would cost a write port per word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      op_write <= 1'b0;
      op_err   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_pin || wr_pin) begin
            op_write <= wr_pin;
            op_err   <= req_err;
            addr_q   <= addr[addr_bits-1:0];
            data_q   <= data_in;
            cnt      <= 8'(latency);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            ack_q <= 1'b1;
            err_q <= op_err;
            if (!op_write && !op_err) data_out <= mem[addr_q];
            state <= ACKED;
          end
        end
        ACKED: begin
          // Pins already low here (master abort) makes ACK a single-cycle pulse.
          if (!rd_pin && !wr_pin) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_stat               = '0;
    ram_stat[`RAM_ACK]     = ack_q;
    ram_stat[`RAM_ERR]     = err_q;
  end

endmodule

// File: tb/tb_ram_unit.sv
// Testbench for ram_unit: directed vector table, multi-cycle corner sequences
// and randomized traffic checked against an array-based memory model.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RAM_READ_PIN
`define RAM_READ_PIN 0
`endif
`ifndef RAM_WRITE_PIN
`define RAM_WRITE_PIN 1
`endif
`ifndef RAM_ACK
`define RAM_ACK 0
`endif
`ifndef RAM_ERR
`define RAM_ERR 1
`endif

module tb_ram_unit;
  localparam int W = `WORD_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] ctrl [2];
  logic [W-1:0] stat [2];
  logic [W-1:0] addr_s [2];
  logic [W-1:0] din [2];
  logic [W-1:0] dout [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-instance word store (addresses 0..15) and last read data.
  logic [W-1:0] model [2][16];
  logic [W-1:0] last  [2];
  int           lat   [2];

  always #5 clk = ~clk;

  ram_unit #(.word_width(W), .addr_bits(10), .latency(2)) dut (
    .clk(clk), .rst_n(rst_n), .ram_ctrl(ctrl[0]), .ram_stat(stat[0]),
    .addr(addr_s[0]), .data_in(din[0]), .data_out(dout[0]));

  ram_unit #(.word_width(W), .addr_bits(10), .latency(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ram_ctrl(ctrl[1]), .ram_stat(stat[1]),
    .addr(addr_s[1]), .data_in(din[1]), .data_out(dout[1]));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pins(input logic rd, input logic wr);
    logic [W-1:0] v;
    v = $urandom;
    v[`RAM_READ_PIN]  = rd;
    v[`RAM_WRITE_PIN] = wr;
    return v;
  endfunction

  // One complete handshake; returns edges from request edge to ACK, and state after drop.
  task automatic xact(input int u, input logic rd, input logic wr, input logic [W-1:0] a,
                      input logic [W-1:0] d, input int hold, input bit scramble,
                      output int edges, output logic err, output logic [W-1:0] rdata,
                      output logic fell);
    logic ack;
    @(negedge clk);
    ctrl[u] = pins(rd, wr);
    addr_s[u] = a;
    din[u] = d;
    @(posedge clk);
    edges = 0;
    ack = 1'b0;
    while (!ack && edges < 300) begin
      @(negedge clk);
      if (scramble) begin
        ctrl[u] = pins(rd, wr);
        addr_s[u] = $urandom;
        din[u] = $urandom;
      end
      @(posedge clk);
      #1;
      edges++;
      ack = stat[u][`RAM_ACK];
    end
    err = stat[u][`RAM_ERR];
    rdata = dout[u];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("ack_hold", stat[u][`RAM_ACK], 1'b1);
    end
    @(negedge clk);
    ctrl[u] = '0;
    @(posedge clk);
    #1;
    fell = (stat[u] == '0);
  endtask

  // Runs one handshake, checks it against the expectations and updates the model.
  task automatic run(input int u, input logic rd, input logic wr, input logic [W-1:0] a,
                     input logic [W-1:0] d, input logic exp_err, input logic [W-1:0] exp_rdata,
                     input int hold, input bit scramble, input string name);
    int           edges;
    logic         err;
    logic [W-1:0] rdata;
    logic         fell;
    xact(u, rd, wr, a, d, hold, scramble, edges, err, rdata, fell);
    check({name, "_ack_edges"}, edges, lat[u] + 1);
    check({name, "_err"}, err, exp_err);
    check({name, "_data_out"}, rdata, exp_rdata);
    check({name, "_ack_fall"}, fell, 1'b1);
    if (!exp_err && wr) model[u][a[3:0]] = d;
    last[u] = exp_rdata;
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic         exp_err;
    logic [W-1:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t         vecs [9];
    logic [W-1:0] a, d, exp_rd;
    logic         rd, wr, exp_err, saw_ack;
    int           u, sel, edges;

    lat[0] = 2;
    lat[1] = 0;
    for (int i = 0; i < 2; i++) begin
      ctrl[i] = '0; addr_s[i] = '0; din[i] = '0; last[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_stat0", stat[0], '0);
    check("reset_dout0", dout[0], '0);
    check("reset_stat1", stat[1], '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload the modelled window so every later read has a known expectation.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        run(k, 1'b0, 1'b1, i, $urandom, 1'b0, last[k], 0, 1'b0, "preload");

    // Directed vectors on the latency-2 instance
    vecs[0] = '{1'b0, 1'b1, 32'd5,     32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd5,     32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd3,     32'hA5A50003, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'd3,     32'hFFFFFFFF, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd3,     32'h0,        1'b0, 32'hA5A50003};
    vecs[5] = '{1'b0, 1'b1, 32'd0,     32'h00001111, 1'b0, 32'hA5A50003};
    vecs[6] = '{1'b0, 1'b1, 32'h400,   32'h00002222, 1'b1, 32'hA5A50003};
    vecs[7] = '{1'b1, 1'b0, 32'd0,     32'h0,        1'b0, 32'h00001111};
    vecs[8] = '{1'b1, 1'b0, 32'h400,   32'h0,        1'b1, 32'h00001111};
    for (int i = 0; i < 9; i++)
      run(0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_err,
          vecs[i].exp_rdata, (i == 1) ? 3 : 0, 1'b0, $sformatf("vec%0d", i));

    // Asynchronous reset mid-clock clears outputs without an edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_stat", stat[0], '0);
    check("async_rst_dout", dout[0], '0);
    last[0] = '0; last[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT aborts the write
    run(0, 1'b0, 1'b1, 32'd7, 32'h00007777, 1'b0, last[0], 0, 1'b0, "old7");
    @(negedge clk);
    ctrl[0] = pins(1'b0, 1'b1); addr_s[0] = 32'd7; din[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("wait_rst_stat", stat[0], '0);
    last[0] = '0; last[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ctrl[0] = '0;
    saw_ack = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      saw_ack |= stat[0][`RAM_ACK];
    end
    check("wait_rst_no_ack", saw_ack, 1'b0);
    run(0, 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 32'h00007777, 0, 1'b0, "read7");

    // Master drops pins during WAIT: access completes, ACK pulses one cycle
    @(negedge clk);
    ctrl[0] = pins(1'b0, 1'b1); addr_s[0] = 32'd9; din[0] = 32'h99990009;
    @(posedge clk);
    @(negedge clk);
    ctrl[0] = '0; addr_s[0] = 32'd4; din[0] = '0;
    edges = 0;
    saw_ack = 1'b0;
    while (!saw_ack && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
      saw_ack = stat[0][`RAM_ACK];
    end
    check("abort_ack_edges", edges, 3);
    @(posedge clk);
    #1;
    check("abort_ack_pulse", stat[0][`RAM_ACK], 1'b0);
    model[0][9] = 32'h99990009;
    run(0, 1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 32'h99990009, 0, 1'b0, "abort_read");

    // Latency 0, back-to-back handshakes
    run(1, 1'b0, 1'b1, 32'd2, 32'hCAFE0002, 1'b0, last[1], 0, 1'b0, "lat0_wr");
    run(1, 1'b1, 1'b0, 32'd2, 32'h0,        1'b0, 32'hCAFE0002, 0, 1'b0, "lat0_rd");

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      u = $urandom_range(0, 1);
      sel = $urandom_range(0, 15);
      rd = (sel < 7) || (sel >= 14);
      wr = (sel >= 7);
      if ($urandom_range(0, 9) == 0) a = (32'd1 << $urandom_range(10, 31)) | $urandom_range(0, 15);
      else a = $urandom_range(0, 15);
      d = $urandom;
      exp_err = (rd && wr) || (a >= 32'd1024);
      exp_rd = (rd && !wr && !exp_err) ? model[u][a[3:0]] : last[u];
      run(u, rd, wr, a, d, exp_err, exp_rd, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
          $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
